// File: rtl/xps2_rx_pkg.sv
//------------------------------------------------------------------------------
// Module : xps2_rx_pkg
// Brief  : Shared register map, status/control bit positions and receiver
//          state encoding for the PS/2 receiver peripheral.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package xps2_rx_pkg;

    localparam logic [1:0] PS2_DATA   = 2'd0;
    localparam logic [1:0] PS2_STATUS = 2'd1;
    localparam logic [1:0] PS2_CTRL   = 2'd2;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_PERR      = 2;
    localparam int STAT_FERR      = 3;
    localparam int STAT_OVF       = 4;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTRL_CLR_ERR = 0;
    localparam int CTRL_FLUSH   = 1;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

`default_nettype wire

// File: rtl/xps2_rx_xfifo.sv
//------------------------------------------------------------------------------
// Module : xps2_rx_xfifo
// Brief  : Synchronous FIFO with push, pop, flush, head, count, full, empty.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module xps2_rx_xfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/xps2_rx.sv
//------------------------------------------------------------------------------
// Module : xps2_rx
// Brief  : PS/2 keyboard receiver with scan-code FIFO and bus registers.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module xps2_rx
    import xps2_rx_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int FILT       = 4,
    parameter int TIMEOUT    = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic              irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = $clog2(FILT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_filt;
    logic [FW-1:0]   r_fcnt;
    logic            w_flip;
    logic            w_fall;

    rx_state_t       r_state;
    logic [7:0]      r_shift;
    logic [2:0]      r_bitcnt;
    logic            r_par;
    logic [TW-1:0]   r_tcnt;
    logic            r_push;
    logic [7:0]      r_push_data;
    logic            r_set_perr;
    logic            r_set_ferr;

    logic            r_perr, r_ferr, r_ovf, r_irq;
    logic [7:0]      w_head;
    logic [CW-1:0]   w_count;
    logic            w_full, w_empty;
    logic            w_pop, w_ctrl_wr, w_clr, w_flush, w_ovf_set;
    logic [DATA_W-1:0] w_rd;
    logic            w_unused_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Filtered clock flips only after FILT consecutive samples disagree with it.
    assign w_flip = (r_clk_s2 != r_filt) && (r_fcnt == FW'(FILT - 1));
    assign w_fall = w_flip & r_filt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt <= 1'b1;
            r_fcnt <= '0;
        end else if (r_clk_s2 == r_filt) begin
            r_fcnt <= '0;
        end else if (w_flip) begin
            r_filt <= r_clk_s2;
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RX_IDLE;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_par       <= 1'b0;
            r_tcnt      <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_set_perr  <= 1'b0;
            r_set_ferr  <= 1'b0;
        end else begin
            r_push     <= 1'b0;
            r_set_perr <= 1'b0;
            r_set_ferr <= 1'b0;
            if (r_state == RX_IDLE || w_fall) r_tcnt <= '0;
            else                              r_tcnt <= r_tcnt + 1'b1;

            if (r_state != RX_IDLE && !w_fall && r_tcnt == TW'(TIMEOUT - 1)) begin
                r_state    <= RX_IDLE;
                r_set_ferr <= 1'b1;
                r_tcnt     <= '0;
            end else if (w_fall) begin
                case (r_state)
                    RX_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state  <= RX_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        r_shift  <= {r_dat_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7) r_state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= RX_STOP;
                    end
                    RX_STOP: begin
                        r_state     <= RX_IDLE;
                        r_push_data <= r_shift;
                        r_push      <= r_dat_s2 & odd_parity_ok(r_shift, r_par);
                        r_set_perr  <= ~odd_parity_ok(r_shift, r_par);
                        r_set_ferr  <= ~r_dat_s2;
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end
        end
    end

    assign w_pop     = sel & ~we & (addr == PS2_DATA) & ~w_empty;
    assign w_ctrl_wr = sel & we & (addr == PS2_CTRL);
    assign w_clr     = w_ctrl_wr & data_in[CTRL_CLR_ERR];
    assign w_flush   = w_ctrl_wr & data_in[CTRL_FLUSH];
    assign w_ovf_set = r_push & w_full & ~w_pop & ~w_flush;
    assign w_unused_data = ^data_in[DATA_W-1:2];

    xps2_rx_xfifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (r_push),
        .i_data  (r_push_data),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A fresh error in the same cycle as a clear keeps its flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_perr <= (r_perr & ~w_clr) | r_set_perr;
            r_ferr <= (r_ferr & ~w_clr) | r_set_ferr;
            r_ovf  <= (r_ovf  & ~w_clr) | w_ovf_set;
            r_irq  <= ~w_empty;
        end
    end

    always_comb begin
        w_rd = '0;
        case (addr)
            PS2_DATA: begin
                if (!w_empty) w_rd[7:0] = w_head;
            end
            PS2_STATUS: begin
                w_rd[STAT_NOT_EMPTY]          = ~w_empty;
                w_rd[STAT_FULL]               = w_full;
                w_rd[STAT_PERR]               = r_perr;
                w_rd[STAT_FERR]               = r_ferr;
                w_rd[STAT_OVF]                = r_ovf;
                w_rd[STAT_COUNT_LSB +: CW]    = w_count;
            end
            default: w_rd = '0;
        endcase
    end

    assign data_out = w_rd;
    assign irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_xps2_rx.sv
//------------------------------------------------------------------------------
// Module : tb_xps2_rx
// Brief  : Self-checking bench for xps2_rx against a frame-level queue model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_xps2_rx;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int FILT  = 4;
    localparam int TMO   = 200;
    localparam int HP    = 12;

    logic          clk, rst, sel, we, pclk, pdat, irq;
    logic [1:0]    addr;
    logic [DW-1:0] data_in, data_out;

    logic [7:0] m_q[$];
    bit         m_perr, m_ferr, m_ovf;
    bit         chk_en;
    int         n_chk, n_err;

    xps2_rx #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .FILT       (FILT),
        .TIMEOUT    (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ps2_clk  (pclk),
        .ps2_data (pdat),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        if (a == 2'd0 && m_q.size() > 0) v[7:0] = m_q[0];
        if (a == 2'd1) begin
            v[0]    = (m_q.size() > 0);
            v[1]    = (m_q.size() == DEPTH);
            v[2]    = m_perr;
            v[3]    = m_ferr;
            v[4]    = m_ovf;
            v[11:8] = 4'(m_q.size());
        end
        return v;
    endfunction

    task automatic m_frame(input logic [7:0] d, input bit badpar, input bit badstop);
        if (badpar)  m_perr = 1'b1;
        if (badstop) m_ferr = 1'b1;
        if (!badpar && !badstop) begin
            if (m_q.size() == DEPTH) m_ovf = 1'b1;
            else                     m_q.push_back(d);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst) begin
            check("irq", 32'(irq), 32'(m_q.size() > 0));
            if (sel && !we) check("rd", data_out, m_reg(addr));
        end
    end

    task automatic ps2_bit(input logic b);
        @(posedge clk); #1 pdat = b;
        repeat (HP) @(posedge clk);
        #1 pclk = 1'b0;
        repeat (HP) @(posedge clk);
        #1 pclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit badpar, input bit badstop);
        chk_en = 1'b0;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(~^d ^ badpar);
        ps2_bit(~badstop);
        pdat = 1'b1;
        repeat (HP) @(posedge clk);
        m_frame(d, badpar, badstop);
        chk_en = 1'b1;
    endtask

    // One quiet cycle lets irq catch up with a pop or flush before checking resumes.
    task automatic settle();
        bit save;
        save   = chk_en;
        chk_en = 1'b0;
        @(posedge clk); #1 chk_en = save;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        @(posedge clk); #1 sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk); v = data_out;
        @(posedge clk); #1 sel = 1'b0;
        if (a == 2'd0 && m_q.size() > 0) void'(m_q.pop_front());
        settle();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1 sel = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(posedge clk); #1 sel = 1'b0; we = 1'b0;
        if (a == 2'd2) begin
            if (d[0]) begin m_perr = 0; m_ferr = 0; m_ovf = 0; end
            if (d[1]) m_q.delete();
        end
        settle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        rst = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0;
        pclk = 1'b1; pdat = 1'b1; chk_en = 1'b0; n_chk = 0; n_err = 0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_data", data_out, 32'd0);
        addr = 2'd1; #1 check("rst_status", data_out, 32'd0);
        addr = 2'd0;
        @(posedge clk); #1 rst = 1'b1; chk_en = 1'b1;

        send_frame(8'h1C, 0, 0);
        @(negedge clk); check("t1_irq", 32'(irq), 32'd1);
        bus_read(2'd1, v); check("t1_status", v, 32'h101);
        bus_read(2'd0, v); check("t1_data", v, 32'h1C);
        bus_read(2'd1, v); check("t1_status_after", v, 32'h0);

        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        bus_read(2'd0, v); check("t2_first", v, 32'hF0);
        bus_read(2'd0, v); check("t2_second", v, 32'h1C);
        @(negedge clk); check("t2_irq_low", 32'(irq), 32'd0);

        send_frame(8'h1C, 1, 0);
        bus_read(2'd1, v); check("t3_perr", v, 32'h004);
        bus_write(2'd2, 32'h1);
        bus_read(2'd1, v); check("t3_cleared", v, 32'h0);
        send_frame(8'h5A, 0, 0);
        bus_read(2'd0, v); check("t3_data", v, 32'h5A);

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
        bus_read(2'd1, v); check("t4_full_ovf", v, 32'h813);
        for (int i = 1; i <= 8; i++) begin
            bus_read(2'd0, v); check("t4_data", v, 32'(i));
        end
        bus_read(2'd1, v); check("t4_ovf_only", v, 32'h010);
        bus_write(2'd2, 32'h1);

        chk_en = 1'b0;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1));
        repeat (TMO + 40) @(posedge clk);
        m_ferr = 1'b1;
        chk_en = 1'b1;
        bus_read(2'd1, v); check("t5_ferr", v, 32'h008);
        send_frame(8'h29, 0, 0);
        bus_read(2'd0, v); check("t5_data", v, 32'h29);
        bus_write(2'd2, 32'h1);

        send_frame(8'h33, 0, 0);
        chk_en = 1'b0;
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t6_rst_irq", 32'(irq), 32'd0);
        check("t6_rst_data", data_out, 32'd0);
        addr = 2'd1; #1 check("t6_rst_status", data_out, 32'd0);
        addr = 2'd0;
        repeat (3) @(posedge clk); #1 rst = 1'b1;
        m_q.delete(); m_perr = 0; m_ferr = 0; m_ovf = 0;
        chk_en = 1'b1;
        bus_read(2'd1, v); check("t6_after_rst", v, 32'h0);

        // Flush lands in the exact cycle the stop-bit push reaches the FIFO.
        chk_en = 1'b0;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(1'(8'h44 >> i));
        ps2_bit(~^8'h44);
        @(posedge clk); #1 pdat = 1'b1;
        repeat (HP) @(posedge clk);
        #1 pclk = 1'b0;
        repeat (2 + FILT) @(posedge clk);
        #1 sel = 1'b1; we = 1'b1; addr = 2'd2; data_in = 32'h2;
        @(posedge clk); #1 sel = 1'b0; we = 1'b0; data_in = '0;
        repeat (HP) @(posedge clk);
        #1 pclk = 1'b1;
        repeat (HP) @(posedge clk);
        chk_en = 1'b1;
        bus_read(2'd1, v); check("t6_flush_wins", v, 32'h0);
        @(negedge clk); check("t6_flush_irq", 32'(irq), 32'd0);

        for (int n = 0; n < 30; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            send_frame(8'($urandom), r < 12, r >= 12 && r < 20);
            for (int k = int'($urandom_range(0, 2)); k > 0; k--) bus_read(2'd0, v);
            r = int'($urandom_range(0, 99));
            if (r < 20)      bus_read(2'd1, v);
            else if (r < 30) bus_read(2'($urandom_range(2, 3)), v);
            else if (r < 45) bus_write(2'd2, {30'($urandom), 2'($urandom_range(1, 3))});
            else if (r < 55) bus_write(2'($urandom_range(0, 1)), $urandom);
            else if (r < 60) bus_write(2'd3, $urandom);
        end
        while (m_q.size() > 0) bus_read(2'd0, v);
        bus_read(2'd1, v);
        bus_read(2'd0, v); check("final_empty_read", v, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
